instr_sequencer: RTL

Multi-cycle control unit for the 16-bit RAM/ROM processor. Fetches instructions through the program counter and memory address register, holds them in an internal instruction register, and drives every datapath strobe: bus source select, register enables, ALU control, `pc_incr`/`pc_in` toward the program counter, and the memory write enable. It sits beside the datapath; every datapath register changes only on the strobes it issues.

---
 rtl/proc_pkg.sv | 44 ++++
 rtl/seq_decode.sv | 100 ++++++++++
 rtl/instr_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor: opcodes, bus source codes,
// sequencer state encoding and the decoded strobe bundle.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_LD   = 3'd4;
  localparam logic [2:0] OP_ST   = 3'd5;
  localparam logic [2:0] OP_MVNZ = 3'd6;
  localparam logic [2:0] OP_JMP  = 3'd7;

  // Codes 0..7 select R0..R7 directly.
  localparam logic [3:0] SEL_G   = 4'd8;
  localparam logic [3:0] SEL_DIN = 4'd9;
  localparam logic [3:0] SEL_PC  = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_F_ADDR = 3'd1,
    S_F_WAIT = 3'd2,
    S_F_LOAD = 3'd3,
    S_EX1    = 3'd4,
    S_EX2    = 3'd5,
    S_EX3    = 3'd6
  } state_t;

  typedef struct packed {
    logic [3:0] bus_sel;
    logic       r_we;
    logic [2:0] r_idx;
    logic       a_in;
    logic       g_in;
    logic       alu_sub;
    logic       addr_in;
    logic       dout_in;
    logic       w_d;
    logic       pc_incr;
    logic       pc_in;
    logic       done;
  } strobes_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational strobe decode from the registered sequencer state and the
// control bits of the instruction register.
module seq_decode
  import proc_pkg::*;
(
  input  state_t     state,
  input  logic [8:0] ir_ctl,
  input  logic       g_nz,
  output strobes_t   strb
);

  logic [2:0] op;
  logic [2:0] x;
  logic [2:0] y;

  assign op = ir_ctl[8:6];
  assign x  = ir_ctl[5:3];
  assign y  = ir_ctl[2:0];

  always_comb begin
    strb = '0;
    case (state)
      S_F_ADDR: begin
        strb.bus_sel = SEL_PC;
        strb.addr_in = 1'b1;
        strb.pc_incr = 1'b1;
      end
      S_EX1: begin
        case (op)
          OP_MV: begin
            strb.bus_sel = {1'b0, y};
            strb.r_we    = 1'b1;
            strb.r_idx   = x;
            strb.done    = 1'b1;
          end
          OP_MVI: begin
            strb.bus_sel = SEL_PC;
            strb.addr_in = 1'b1;
            strb.pc_incr = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            strb.bus_sel = {1'b0, x};
            strb.a_in    = 1'b1;
          end
          OP_LD, OP_ST: begin
            strb.bus_sel = {1'b0, y};
            strb.addr_in = 1'b1;
          end
          OP_MVNZ: begin
            // The instruction completes whether or not the move happens.
            strb.bus_sel = {1'b0, y};
            strb.r_we    = g_nz;
            strb.r_idx   = x;
            strb.done    = 1'b1;
          end
          default: begin
            strb.bus_sel = {1'b0, y};
            strb.pc_in   = 1'b1;
            strb.done    = 1'b1;
          end
        endcase
      end
      S_EX2: begin
        case (op)
          OP_ADD, OP_SUB: begin
            strb.bus_sel = {1'b0, y};
            strb.g_in    = 1'b1;
            strb.alu_sub = op[0];
          end
          OP_ST: begin
            strb.bus_sel = {1'b0, x};
            strb.dout_in = 1'b1;
            strb.w_d     = 1'b1;
            strb.done    = 1'b1;
          end
          default: ;
        endcase
      end
      S_EX3: begin
        case (op)
          OP_MVI, OP_LD: begin
            strb.bus_sel = SEL_DIN;
            strb.r_we    = 1'b1;
            strb.r_idx   = x;
            strb.done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            strb.bus_sel = SEL_G;
            strb.r_we    = 1'b1;
            strb.r_idx   = x;
            strb.done    = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit: fetch through PC/address register, hold the
// instruction in IR, and issue every datapath strobe.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [15:0]      DIN,
  input  logic             G_nz,
  output logic [3:0]       bus_sel,
  output logic [NREGS-1:0] R_in,
  output logic             A_in,
  output logic             G_in,
  output logic             alu_sub,
  output logic             addr_in,
  output logic             dout_in,
  output logic             W_D,
  output logic             pc_incr,
  output logic             pc_in,
  output logic [15:0]      IR,
  output logic             Done,
  output logic [2:0]       dbg_state
);

  state_t   state;
  state_t   state_nxt;
  strobes_t strb;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= S_IDLE;
      IR    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_F_LOAD) IR <= DIN;
    end
  end

  // Run only matters when idle or on the Done cycle of an instruction.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = Run ? S_F_ADDR : S_IDLE;
      S_F_ADDR: state_nxt = S_F_WAIT;
      S_F_WAIT: state_nxt = S_F_LOAD;
      S_F_LOAD: state_nxt = S_EX1;
      S_EX1:    state_nxt = strb.done ? (Run ? S_F_ADDR : S_IDLE) : S_EX2;
      S_EX2:    state_nxt = strb.done ? (Run ? S_F_ADDR : S_IDLE) : S_EX3;
      S_EX3:    state_nxt = Run ? S_F_ADDR : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  seq_decode u_decode (
    .state  (state),
    .ir_ctl (IR[15:7]),
    .g_nz   (G_nz),
    .strb   (strb)
  );

  always_comb begin
    bus_sel = strb.bus_sel;
    A_in    = strb.a_in;
    G_in    = strb.g_in;
    alu_sub = strb.alu_sub;
    addr_in = strb.addr_in;
    dout_in = strb.dout_in;
    W_D     = strb.w_d;
    pc_incr = strb.pc_incr;
    pc_in   = strb.pc_in;
    Done    = strb.done;
    for (int i = 0; i < NREGS; i++) begin
      R_in[i] = strb.r_we && (32'(strb.r_idx) == i);
    end
  end

  assign dbg_state = state;

endmodule
